pixel_upscaler: RTL

PIXEL_UPSCALER -- requirements
Module: pixel_upscaler

---
 rtl/video_pkg.sv | 24 ++
 rtl/pixel_upscaler_addr_gen.sv | 52 +++++
 rtl/pixel_upscaler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: default source geometry, bus widths, upscaler
// FSM encoding and the replication factor encoding.
package video_pkg;

  localparam int VID_SRC_W = 160;
  localparam int VID_SRC_H = 120;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 8;
  localparam int REP_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  typedef enum logic {
    FACTOR_2 = 1'b0,
    FACTOR_4 = 1'b1
  } factor_t;

endpackage

// File: rtl/pixel_upscaler_addr_gen.sv
// Destination address generator for the pixel upscaler.
// dst_addr = (sy*F + dy) * (SRC_W*F) + sx*F + dx, built from shifts and adds.
// F is a power of two, so every multiply by F is a shift.
// The multiply by SRC_W is a constant shift-and-add chain.
// The F=4 shift path exists only when UPSCALE_4X_EN is defined.
module upscale_addr_gen
  import video_pkg::*;
#(
  parameter int SRC_W = VID_SRC_W,
  parameter int SX_W  = 8,
  parameter int SY_W  = 7
) (
  input  logic [SX_W-1:0]   sx,
  input  logic [SY_W-1:0]   sy,
  input  logic [REP_W-1:0]  dx,
  input  logic [REP_W-1:0]  dy,
  input  factor_t           factor,
  output logic [ADDR_W-1:0] dst_addr
);

  localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(SRC_W);

  logic [1:0]        fsh;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  // Shift-and-add multiply by the constant source width.
  function automatic logic [ADDR_W-1:0] mul_row_len(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (ROW_LEN[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

`ifdef UPSCALE_4X_EN
  assign fsh = (factor == FACTOR_4) ? 2'd2 : 2'd1;
`else
  logic unused_factor;
  assign unused_factor = factor;
  assign fsh = 2'd1;
`endif

  // Destination row/column, then linear address; row length is SRC_W*F.
  always_comb begin
    row      = (ADDR_W'(sy) << fsh) + ADDR_W'(dy);
    col      = (ADDR_W'(sx) << fsh) + ADDR_W'(dx);
    dst_addr = (mul_row_len(row) << fsh) + col;
  end

endmodule

// File: rtl/pixel_upscaler.sv
// Pixel upscaler: reads each source pixel once and writes it as an FxF block
// of replicas into the destination framebuffer (F = 2, or 4 via mode_4x).
// Optional feature macro: UPSCALE_4X_EN enables the F=4 mode; without it
// F is fixed at 2 and mode_4x is ignored.
module pixel_upscaler
  import video_pkg::*;
#(
  parameter int SRC_W = VID_SRC_W,
  parameter int SRC_H = VID_SRC_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_4x,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_wren,
  output logic              busy,
  output logic              done
);

  localparam int SX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int SY_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam logic [SX_W-1:0] SX_LAST = SX_W'(SRC_W - 1);
  localparam logic [SY_W-1:0] SY_LAST = SY_W'(SRC_H - 1);

  state_t            state;
  factor_t           factor;
  logic [SX_W-1:0]   sx;
  logic [SY_W-1:0]   sy;
  logic [REP_W-1:0]  dx;
  logic [REP_W-1:0]  dy;
  logic [REP_W-1:0]  nxt_dx;
  logic [REP_W-1:0]  nxt_dy;
  logic [REP_W-1:0]  f_last;
  logic              rep_last;
  logic [ADDR_W-1:0] gen_addr;

`ifdef UPSCALE_4X_EN
  // Latch the replication factor when a frame is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      factor <= FACTOR_2;
    end else if (state == ST_IDLE && start) begin
      factor <= mode_4x ? FACTOR_4 : FACTOR_2;
    end
  end

  assign f_last = (factor == FACTOR_4) ? 2'd3 : 2'd1;
`else
  logic unused_mode;
  assign unused_mode = mode_4x;
  assign factor      = FACTOR_2;
  assign f_last      = 2'd1;
`endif

  // Next replica within the FxF block (raster order, dx fastest); zero outside WRITE
  // so the WAIT->WRITE edge loads the address of replica (0,0).
  always_comb begin
    nxt_dx   = '0;
    nxt_dy   = '0;
    rep_last = 1'b0;
    if (state == ST_WRITE) begin
      rep_last = (dx == f_last) && (dy == f_last);
      if (dx == f_last) begin
        nxt_dx = '0;
        nxt_dy = dy + REP_W'(1);
      end else begin
        nxt_dx = dx + REP_W'(1);
        nxt_dy = dy;
      end
    end
  end

  upscale_addr_gen #(
    .SRC_W (SRC_W),
    .SX_W  (SX_W),
    .SY_W  (SY_W)
  ) u_addr_gen (
    .sx       (sx),
    .sy       (sy),
    .dx       (nxt_dx),
    .dy       (nxt_dy),
    .factor   (factor),
    .dst_addr (gen_addr)
  );

  // Frame sequencer: fetch one source pixel, wait for the RAM, write F*F replicas.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
      dst_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sx       <= '0;
      sy       <= '0;
      dx       <= '0;
      dy       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            done     <= 1'b0;
            busy     <= 1'b1;
            src_addr <= '0;
            sx       <= '0;
            sy       <= '0;
            dx       <= '0;
            dy       <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          dst_data <= src_data;
          dst_addr <= gen_addr;
          dst_wren <= 1'b1;
          dx       <= '0;
          dy       <= '0;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          if (rep_last) begin
            dst_wren <= 1'b0;
            if (sx == SX_LAST) begin
              sx <= '0;
              if (sy == SY_LAST) begin
                state <= ST_FINISH;
              end else begin
                sy       <= sy + SY_W'(1);
                src_addr <= src_addr + ADDR_W'(1);
                state    <= ST_FETCH;
              end
            end else begin
              sx       <= sx + SX_W'(1);
              src_addr <= src_addr + ADDR_W'(1);
              state    <= ST_FETCH;
            end
          end else begin
            dx       <= nxt_dx;
            dy       <= nxt_dy;
            dst_addr <= gen_addr;
          end
        end
        ST_FINISH: begin
          busy     <= 1'b0;
          dst_wren <= 1'b0;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
